// File: rtl/synth_pkg.sv
// Shared types and fixed-point helpers for the synth voice blocks
// (envelope, oscillator, multiplier).
package synth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int unsigned DEFAULT_TOTAL_BITS      = 16;
  localparam int unsigned DEFAULT_FRACTIONAL_BITS = 8;

  // Unity gain in U(W,F): 1 << F.
  function automatic logic [31:0] fx_one(input int unsigned fractional_bits);
    return 32'd1 << fractional_bits;
  endfunction

endpackage

// File: rtl/env_step.sv
// Combinational next-state/next-level logic for one envelope tick.
// Arithmetic is widened by one bit so sums and thresholds never wrap.
module env_step
  import synth_pkg::*;
#(
  parameter int unsigned TOTAL_BITS      = DEFAULT_TOTAL_BITS,
  parameter int unsigned FRACTIONAL_BITS = DEFAULT_FRACTIONAL_BITS
) (
  input  logic [2:0]            state,
  input  logic [TOTAL_BITS-1:0] level,
  input  logic [TOTAL_BITS-1:0] attack_rate,
  input  logic [TOTAL_BITS-1:0] decay_rate,
  input  logic [TOTAL_BITS-1:0] release_rate,
  input  logic [TOTAL_BITS-1:0] sustain_s,
  input  logic                  rise,
  input  logic                  fall,
  output logic [TOTAL_BITS-1:0] next_level,
  output logic [2:0]            next_state
);

  localparam logic [TOTAL_BITS-1:0] ONE_W = TOTAL_BITS'(fx_one(FRACTIONAL_BITS));
  localparam logic [TOTAL_BITS:0]   ONE_X = (TOTAL_BITS + 1)'(fx_one(FRACTIONAL_BITS));

  logic [TOTAL_BITS:0]   attack_sum;
  logic [TOTAL_BITS:0]   decay_floor;
  logic                  attack_done;
  logic                  decay_done;
  logic                  release_done;
  logic [TOTAL_BITS-1:0] attack_level;
  logic [2:0]            attack_state;
  logic [TOTAL_BITS-1:0] release_level;
  logic [2:0]            release_state;

  always_comb begin
    attack_sum   = {1'b0, level} + {1'b0, attack_rate};
    decay_floor  = {1'b0, sustain_s} + {1'b0, decay_rate};
    attack_done  = (attack_rate == '0) || (attack_sum >= ONE_X);
    decay_done   = (decay_rate == '0) || ({1'b0, level} <= decay_floor);
    release_done = (release_rate == '0) || (level <= release_rate);

    attack_level  = attack_done ? ONE_W : attack_sum[TOTAL_BITS-1:0];
    attack_state  = attack_done ? DECAY : ATTACK;
    release_level = release_done ? '0 : (level - release_rate);
    release_state = release_done ? IDLE : RELEASE;
  end

  // Edge-driven transitions take priority over the per-phase step.
  always_comb begin
    next_level = level;
    next_state = state;
    if (rise) begin
      next_level = attack_level;
      next_state = attack_state;
    end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      next_level = release_level;
      next_state = release_state;
    end else begin
      case (state)
        IDLE: begin
          next_level = '0;
          next_state = IDLE;
        end
        ATTACK: begin
          next_level = attack_level;
          next_state = attack_state;
        end
        DECAY: begin
          next_level = decay_done ? sustain_s : (level - decay_rate);
          next_state = decay_done ? SUSTAIN : DECAY;
        end
        SUSTAIN: begin
          next_level = sustain_s;
          next_state = SUSTAIN;
        end
        RELEASE: begin
          next_level = release_level;
          next_state = release_state;
        end
        default: begin
          next_level = '0;
          next_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Linear ADSR envelope: holds the registered level/state and gates every
// update on the sample tick; the per-tick math lives in env_step.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int unsigned TOTAL_BITS      = DEFAULT_TOTAL_BITS,
  parameter int unsigned FRACTIONAL_BITS = DEFAULT_FRACTIONAL_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  gate,
  input  logic [TOTAL_BITS-1:0] attack_rate,
  input  logic [TOTAL_BITS-1:0] decay_rate,
  input  logic [TOTAL_BITS-1:0] sustain_level,
  input  logic [TOTAL_BITS-1:0] release_rate,
  output logic [TOTAL_BITS-1:0] level,
  output logic                  level_valid,
  output logic [2:0]            state,
  output logic                  active
);

  localparam logic [TOTAL_BITS-1:0] ONE_W = TOTAL_BITS'(fx_one(FRACTIONAL_BITS));

  logic [TOTAL_BITS-1:0] level_q, level_d;
  logic [2:0]            state_q, state_d;
  logic                  level_valid_q, level_valid_d;
  logic                  gate_q, gate_d;

  logic [TOTAL_BITS-1:0] sustain_s;
  logic                  rise;
  logic                  fall;
  logic [TOTAL_BITS-1:0] step_level;
  logic [2:0]            step_state;

  always_comb begin
    sustain_s = (sustain_level > ONE_W) ? ONE_W : sustain_level;
    rise      = gate & ~gate_q;
    fall      = ~gate & gate_q;
  end

  env_step #(
    .TOTAL_BITS      (TOTAL_BITS),
    .FRACTIONAL_BITS (FRACTIONAL_BITS)
  ) u_env_step (
    .state        (state_q),
    .level        (level_q),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .release_rate (release_rate),
    .sustain_s    (sustain_s),
    .rise         (rise),
    .fall         (fall),
    .next_level   (step_level),
    .next_state   (step_state)
  );

  // Gate edges are only meaningful relative to the previous tick's gate.
  always_comb begin
    level_d       = level_q;
    state_d       = state_q;
    gate_d        = gate_q;
    level_valid_d = 1'b0;
    if (tick) begin
      level_d       = step_level;
      state_d       = step_state;
      gate_d        = gate;
      level_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q       <= '0;
      state_q       <= IDLE;
      level_valid_q <= 1'b0;
      gate_q        <= 1'b0;
    end else begin
      level_q       <= level_d;
      state_q       <= state_d;
      level_valid_q <= level_valid_d;
      gate_q        <= gate_d;
    end
  end

  assign level       = level_q;
  assign state       = state_q;
  assign level_valid = level_valid_q;
  assign active      = (state_q != IDLE);

endmodule
